rng_lfsr_gen: RTL and testbench

//  Parametrised pseudo-random source: Galois LFSR of configurable width and taps,

---
 rtl/rng_lfsr_gen.sv | 118 +++++++++++
 tb/tb_rng_lfsr_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_lfsr_gen.sv
// -----------------------------------------------------------------------------
// rng_lfsr_gen
//   Parametrised pseudo-random sample source built on a Galois LFSR. The seed
//   can be reloaded at run time. Samples can be limited to [0, limit-1] by
//   rejection sampling. Samples leave through a one-entry valid/ready output
//   slot.
//
// Handshake: a sample transfers on a rising edge where out_valid & out_ready.
//   While out_valid is high and out_ready is low, out, out_valid and state all
//   hold. out_valid never depends combinationally on out_ready.
//
// Parameters
//   WIDTH  LFSR state width (>= OUT_W, >= 3)
//   TAPS   Galois feedback mask
//   SEED   reset seed; it also replaces any all-zero seed load
//   OUT_W  output sample width
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   en         in   allow LFSR stepping / sample generation
//   seed_load  in   load seed_in this cycle (wins over en)
//   seed_in    in   seed value
//   limit      in   samples restricted to [0, limit-1]; 0 = full range
//   out        out  current sample
//   out_valid  out  out holds an accepted, unconsumed sample (FSM FULL)
//   out_ready  in   consumer accepts the sample
//   wrap       out  1-cycle pulse when the LFSR steps back to the last seed
//   state      out  raw LFSR state (debug)
// -----------------------------------------------------------------------------
module rng_lfsr_gen #(
    parameter int unsigned           WIDTH = 16,
    parameter logic [WIDTH-1:0]      TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0]      SEED  = 16'hACE1,
    parameter int unsigned           OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [OUT_W-1:0] limit,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic [WIDTH-1:0] state
);

    // The output slot state is the FSM; out_valid is exactly (fsm_q == FULL).
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } fsm_t;

    fsm_t             fsm_q;
    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] last_seed_q;
    logic [OUT_W-1:0] out_q;
    logic             wrap_q;

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] seed_d;
    logic [OUT_W-1:0] cand;
    logic             slot_free;
    logic             step;
    logic             accept;
    logic             consume;

    always_comb begin
        // Galois step: shift right and fold in the taps when bit 0 leaves.
        state_d   = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
        cand      = state_d[OUT_W-1:0];
        // An all-zero state locks the LFSR, so a zero seed becomes SEED.
        seed_d    = (seed_in == '0) ? SEED : seed_in;
        consume   = (fsm_q == FULL) && out_ready;
        slot_free = (fsm_q == EMPTY) || out_ready;
        step      = en && slot_free && !seed_load;
        accept    = (limit == '0) || (cand < limit);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q       <= EMPTY;
            state_q     <= SEED;
            last_seed_q <= SEED;
            out_q       <= '0;
            wrap_q      <= 1'b0;
        end else if (seed_load) begin
            // Any held sample is dropped; out keeps its last value.
            fsm_q       <= EMPTY;
            state_q     <= seed_d;
            last_seed_q <= seed_d;
            wrap_q      <= 1'b0;
        end else if (step) begin
            state_q <= state_d;
            wrap_q  <= (state_d == last_seed_q);
            if (accept) begin
                out_q <= cand;
                fsm_q <= FULL;
            end else if (consume) begin
                // Rejected candidate while the old sample leaves: slot empties.
                fsm_q <= EMPTY;
            end
        end else begin
            wrap_q <= 1'b0;
            if (consume) begin
                fsm_q <= EMPTY;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = (fsm_q == FULL);
    assign wrap      = wrap_q;
    assign state     = state_q;

endmodule

// File: tb/tb_rng_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_rng_lfsr_gen
//   Directed steps in one initial block. Expected samples are queued when the
//   stimulus is applied and popped when a valid & ready transfer is seen.
// -----------------------------------------------------------------------------
module tb_rng_lfsr_gen;

    localparam int W = 16;
    localparam int OW = 5;
    localparam logic [W-1:0] TAPS = 16'hB400;
    localparam logic [W-1:0] SEED = 16'hACE1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed_in = '0;
    logic [OW-1:0] limit = '0;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out;
    logic          out_valid;
    logic          wrap;
    logic [W-1:0]  state;

    always #5 clk = ~clk;

    rng_lfsr_gen #(
        .WIDTH(W),
        .TAPS (TAPS),
        .SEED (SEED),
        .OUT_W(OW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .limit    (limit),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .wrap     (wrap),
        .state    (state)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          sb_on = 1'b0;
    int            consumed = 0;

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 16'h0000);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record a transfer seen at this (negedge) point, then advance
    // to the next negedge where outputs are stable.
    task automatic cyc();
        logic [OW-1:0] e;
        if (sb_on && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed sample=%0d expected none", out);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_sample", {27'd0, out}, {27'd0, e});
                consumed++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; seed_load = 1'b0; out_ready = 1'b0; limit = '0;
        cyc();
        cyc();
        exp_q.delete();
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    int            wrap_cnt;
    int            wrap_at;
    int            zero_hits;
    logic [W-1:0]  state_at_wrap;
    logic [W-1:0]  ms;
    logic [OW-1:0] mc;
    logic [OW-1:0] rlim;
    int            guard;

    initial begin
        @(negedge clk);
        do_reset();
        rst = 1'b0;
        cyc();
        check("rst_out", {27'd0, out}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_state", {16'd0, state}, 32'hACE1);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        sb_on = 1'b1;

        // 1: full range stream
        rst = 1'b1; en = 1'b1; out_ready = 1'b1; limit = '0;
        exp_q.push_back(5'd16); exp_q.push_back(5'd24); exp_q.push_back(5'd28);
        cyc();
        check("t1_state1", {16'd0, state}, 32'hE270);
        check("t1_valid1", {31'd0, out_valid}, 32'd1);
        cyc();
        check("t1_state2", {16'd0, state}, 32'h7138);
        cyc();
        check("t1_state3", {16'd0, state}, 32'h389C);
        en = 1'b0;
        cyc();                                   // consume without step
        check("t1_valid_drain", {31'd0, out_valid}, 32'd0);
        check("t1_out_kept", {27'd0, out}, 32'd28);
        check("t1_state_hold", {16'd0, state}, 32'h389C);
        check("t1_q_empty", exp_q.size(), 32'd0);

        // 2: limit = 20, rejections
        do_reset();
        en = 1'b1; out_ready = 1'b1; limit = 5'd20;
        exp_q.push_back(5'd16); exp_q.push_back(5'd14);
        cyc();
        check("t2_valid1", {31'd0, out_valid}, 32'd1);
        cyc();
        check("t2_rej24_valid", {31'd0, out_valid}, 32'd0);
        check("t2_rej24_out", {27'd0, out}, 32'd16);
        cyc();
        check("t2_rej28_valid", {31'd0, out_valid}, 32'd0);
        check("t2_rej28_state", {16'd0, state}, 32'h389C);
        cyc();
        check("t2_valid4", {31'd0, out_valid}, 32'd1);
        en = 1'b0;
        cyc();
        check("t2_q_empty", exp_q.size(), 32'd0);

        // 3: backpressure
        do_reset();
        en = 1'b1; out_ready = 1'b1; limit = '0;
        exp_q.push_back(5'd16); exp_q.push_back(5'd24);
        cyc();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t3_hold_out", {27'd0, out}, 32'd16);
            check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t3_hold_state", {16'd0, state}, 32'hE270);
        end
        out_ready = 1'b1;
        cyc();
        check("t3_resume_state", {16'd0, state}, 32'h7138);
        check("t3_resume_out", {27'd0, out}, 32'd24);
        en = 1'b0;
        cyc();
        check("t3_q_empty", exp_q.size(), 32'd0);

        // 4: seed load, zero seed substitution, priority over en
        en = 1'b1; out_ready = 1'b1;
        cyc();                                   // 0x7138 -> 0x389C, out=28 held
        out_ready = 1'b0; seed_load = 1'b1; seed_in = 16'h0000;
        cyc();
        check("t4_zero_seed_state", {16'd0, state}, 32'hACE1);
        check("t4_load_valid", {31'd0, out_valid}, 32'd0);
        check("t4_load_out", {27'd0, out}, 32'd28);
        check("t4_load_wrap", {31'd0, wrap}, 32'd0);
        out_ready = 1'b1; seed_in = 16'h0001;
        cyc();
        check("t4_seed1_state", {16'd0, state}, 32'h0001);
        seed_load = 1'b0;
        exp_q.push_back(5'd0);
        cyc();
        check("t4_step_state", {16'd0, state}, 32'hB400);
        check("t4_step_valid", {31'd0, out_valid}, 32'd1);
        check("t4_step_wrap", {31'd0, wrap}, 32'd0);
        en = 1'b0;
        cyc();
        check("t4_q_empty", exp_q.size(), 32'd0);

        // 6: reset while a sample is held under backpressure
        do_reset();
        en = 1'b1; out_ready = 1'b1;
        exp_q.push_back(5'd16);
        cyc();
        out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        check("t6_out", {27'd0, out}, 32'd0);
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_state", {16'd0, state}, 32'hACE1);
        exp_q.delete();

        // 7: random limit and random ready, expected stream from a model
        do_reset();
        rlim = 5'($urandom_range(1, 31));
        ms = SEED;
        guard = 0;
        while (exp_q.size() < 200 && guard < 20000) begin
            ms = lfsr_next(ms);
            mc = ms[OW-1:0];
            if (mc < rlim) exp_q.push_back(mc);
            guard++;
        end
        limit = rlim; en = 1'b1; consumed = 0;
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        en = 1'b0; out_ready = 1'b1;
        cyc();
        check("t7_drained", {31'd0, out_valid}, 32'd0);
        exp_q.delete();

        // 5: full period, wrap exactly once, never zero
        sb_on = 1'b0;
        do_reset();
        en = 1'b1; out_ready = 1'b1; limit = '0;
        wrap_cnt = 0; wrap_at = 0; zero_hits = 0; state_at_wrap = '0;
        for (int i = 1; i <= 65537; i++) begin
            cyc();
            if (state == '0) zero_hits++;
            if (wrap === 1'b1) begin
                wrap_cnt++;
                wrap_at = i;
                state_at_wrap = state;
            end
        end
        check("t5_wrap_count", wrap_cnt, 32'd1);
        check("t5_wrap_step", wrap_at, 32'd65535);
        check("t5_wrap_state", {16'd0, state_at_wrap}, 32'hACE1);
        check("t5_zero_hits", zero_hits, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
